// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for one logic block: preamble search, shadow shift-in,
// even-parity check and atomic commit of the live configuration word.
module clb_cfg_loader #(
    parameter int               CFGW = 37,
    parameter int               PREW = 4,
    parameter logic [PREW-1:0]  PRE  = 4'b1011
) (
    input  logic            K,
    input  logic            RST,
    input  logic            DIN,
    input  logic            DVALID,
    input  logic            ABORT,
    output logic [CFGW-1:0] CFG,
    output logic            HOLD,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR
);

    // Default word: mux selects, 16-bit LUT init, combo option, DQ muxes, flop/latch
    localparam logic [CFGW-1:0] CFG_RST = {2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                                           16'b0000000100010110, 2'b00,
                                           3'b000, 3'b111, 2'b00, 1'b0};
    localparam logic [5:0] CNT_MAX  = 6'(CFGW);
    localparam logic [5:0] CNT_LAST = 6'(CFGW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [PREW-1:0] sync_reg, sync_next;
    logic [CFGW-1:0] shadow_reg, shadow_next;
    logic [5:0]      cnt_reg, cnt_next;
    logic            par_reg, par_next;
    logic [CFGW-1:0] cfg_reg, cfg_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;

    logic [CFGW-1:0] shadow_shift;
    logic [PREW-1:0] sync_shift;

    // Shifted copies with DIN entering at the LSB, so the first-received bit ends up MSB
    genvar gi;
    generate
        for (gi = 0; gi < CFGW; gi++) begin : g_shadow
            if (gi == 0) begin : g_lsb
                assign shadow_shift[gi] = DIN;
            end else begin : g_bit
                assign shadow_shift[gi] = shadow_reg[gi-1];
            end
        end
        for (gi = 0; gi < PREW; gi++) begin : g_sync
            if (gi == 0) begin : g_lsb
                assign sync_shift[gi] = DIN;
            end else begin : g_bit
                assign sync_shift[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        sync_next   = sync_reg;
        shadow_next = shadow_reg;
        cnt_next    = cnt_reg;
        par_next    = par_reg;
        cfg_next    = cfg_reg;
        done_next   = 1'b0;
        err_next    = err_reg;

        case (state_reg)
            IDLE: begin
                if (DVALID) begin
                    sync_next = sync_shift;
                    if (sync_shift == PRE) begin
                        state_next = LOAD;
                        sync_next  = '0;
                        err_next   = 1'b0;
                        cnt_next   = '0;
                        par_next   = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (ABORT) begin
                    state_next  = IDLE;
                    sync_next   = '0;
                    shadow_next = '0;
                end else if (DVALID) begin
                    shadow_next = shadow_shift;
                    par_next    = par_reg ^ DIN;
                    if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + 6'd1;
                    end
                    if (cnt_reg == CNT_LAST) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                // Abort outranks a parity bit arriving on the same edge
                if (ABORT) begin
                    state_next  = IDLE;
                    sync_next   = '0;
                    shadow_next = '0;
                end else if (DVALID) begin
                    state_next = IDLE;
                    sync_next  = '0;
                    if ((par_reg ^ DIN) == 1'b0) begin
                        cfg_next  = shadow_reg;
                        done_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sync_next  = '0;
            end
        endcase
    end

    always_ff @(posedge K) begin
        if (RST) begin
            state_reg  <= IDLE;
            sync_reg   <= '0;
            shadow_reg <= '0;
            cnt_reg    <= '0;
            par_reg    <= 1'b0;
            cfg_reg    <= CFG_RST;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sync_reg   <= sync_next;
            shadow_reg <= shadow_next;
            cnt_reg    <= cnt_next;
            par_reg    <= par_next;
            cfg_reg    <= cfg_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign CFG  = cfg_reg;
    assign HOLD = (state_reg == LOAD) || (state_reg == PARITY);
    assign BUSY = (state_reg != IDLE);
    assign DONE = done_reg;
    assign ERR  = err_reg;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Bench for clb_cfg_loader: reset checks, a fixed vector table, hand-written corner
// sequences and randomized frames compared cycle by cycle against a queue-based model.
module tb_clb_cfg_loader;

    localparam int CFGW = 37;
    localparam logic [CFGW-1:0] CFG_DEF = 37'h150008B038;
    localparam logic [CFGW-1:0] ONES    = {CFGW{1'b1}};

    logic            K = 1'b0;
    logic            RST, DIN, DVALID, ABORT;
    logic [CFGW-1:0] CFG;
    logic            HOLD, BUSY, DONE, ERR;

    clb_cfg_loader dut (
        .K(K), .RST(RST), .DIN(DIN), .DVALID(DVALID), .ABORT(ABORT),
        .CFG(CFG), .HOLD(HOLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 K = ~K;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit saw_done = 0;
    bit saw_busy = 0;
    logic [3:0] pre_pat = 4'b1011;

    // Reference model: frames tracked as bit queues, parity by counting ones
    bit              m_busy, m_err, m_done;
    logic [CFGW-1:0] m_cfg;
    bit              hist[$];
    bit              payload[$];

    task automatic model_step(input bit din, input bit dv, input bit ab, input bit rst);
        int ones;
        if (rst) begin
            m_busy = 0; m_err = 0; m_done = 0; m_cfg = CFG_DEF;
            hist.delete(); payload.delete();
            return;
        end
        m_done = 0;
        if (m_busy && ab) begin
            m_busy = 0;
            payload.delete();
            hist.delete();
        end else if (dv) begin
            if (!m_busy) begin
                hist.push_back(din);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hist.size() == 4 && hist[0] == pre_pat[3] && hist[1] == pre_pat[2] &&
                    hist[2] == pre_pat[1] && hist[3] == pre_pat[0]) begin
                    m_busy = 1; m_err = 0;
                    hist.delete(); payload.delete();
                end
            end else if (payload.size() < CFGW) begin
                payload.push_back(din);
            end else begin
                ones = int'(din);
                foreach (payload[k]) ones += int'(payload[k]);
                if (ones % 2 == 0) begin
                    for (int k = 0; k < CFGW; k++) m_cfg[CFGW-1-k] = payload[k];
                    m_done = 1;
                end else begin
                    m_err = 1;
                end
                m_busy = 0;
                payload.delete();
                hist.delete();
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cyc %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    task automatic apply(input bit din, input bit dv, input bit ab, input bit rst);
        @(negedge K);
        DIN = din; DVALID = dv; ABORT = ab; RST = rst;
        @(posedge K);
        #1;
        cyc++;
        model_step(din, dv, ab, rst);
        if (DONE) begin
            saw_done = 1;
            $display("cyc %0d: commit cfg=%h", cyc, CFG);
        end
        if (BUSY) saw_busy = 1;
        check("model", {CFG, HOLD, BUSY, DONE, ERR}, {m_cfg, m_busy, m_busy, m_done, m_err});
    endtask

    function automatic bit frame_bit(input logic [CFGW-1:0] p, input bit good, input int i);
        if (i < 4) return pre_pat[3-i];
        if (i < 4 + CFGW) return p[CFGW-1-(i-4)];
        return (^p) ^ !good;
    endfunction

    // Whole frame with random DVALID gaps; abort_at >= 0 aborts on that frame bit
    task automatic send_frame(input logic [CFGW-1:0] p, input bit good, input int gap_pct,
                              input int abort_at);
        $display("frame: payload=%h good=%0d abort_at=%0d", p, good, abort_at);
        for (int i = 0; i < 4 + CFGW + 1; i++) begin
            while ($urandom_range(99) < gap_pct) apply(1'($urandom), 1'b0, 1'b0, 1'b0);
            if (i == abort_at) begin
                apply(frame_bit(p, good, i), 1'b1, 1'b1, 1'b0);
                return;
            end
            apply(frame_bit(p, good, i), 1'b1, 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        bit              din;
        logic [CFGW-1:0] cfg;
        bit              busy;
        bit              done;
        bit              err;
    } vec_t;
    vec_t tbl[126];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_match, t_done;
        bit hold_drop;
        logic [CFGW-1:0] p1, p2, pr;
        bit b;

        // Three back-to-back frames: good all-ones, bad parity, good all-zeros
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 42; i++) begin
                int k;
                k = f * 42 + i;
                if (i < 4)       tbl[k].din = pre_pat[3-i];
                else if (i < 41) tbl[k].din = (f != 2);
                else             tbl[k].din = (f == 0);
                tbl[k].busy = (i >= 3 && i <= 40);
                tbl[k].done = (i == 41) && (f != 1);
                if (f == 0)      tbl[k].cfg = (i == 41) ? ONES : CFG_DEF;
                else if (f == 1) tbl[k].cfg = ONES;
                else             tbl[k].cfg = (i == 41) ? '0 : ONES;
                if (f == 0)      tbl[k].err = 0;
                else if (f == 1) tbl[k].err = (i == 41);
                else             tbl[k].err = (i < 3);
            end
        end

        RST = 1'b1; DIN = 1'b0; DVALID = 1'b0; ABORT = 1'b0;
        apply(0, 0, 0, 1);
        apply(0, 0, 0, 1);
        check("reset_cfg", CFG, CFG_DEF);
        check("reset_flags", {HOLD, BUSY, DONE, ERR}, 4'b0000);

        saw_busy = 0;
        for (int i = 0; i < 20; i++) apply(1, 1, 0, 0);
        check("ones_no_busy", saw_busy, 0);

        for (int k = 0; k < 126; k++) begin
            apply(tbl[k].din, 1, 0, 0);
            check("table", {CFG, BUSY, DONE, ERR},
                  {tbl[k].cfg, tbl[k].busy, tbl[k].done, tbl[k].err});
        end

        // Good frame with DVALID low every other cycle
        t_match = -1; t_done = -1; hold_drop = 0;
        for (int i = 0; i < 42; i++) begin
            apply(frame_bit(ONES, 1, i), 1, 0, 0);
            if (i == 3) t_match = cyc;
            if (DONE) t_done = cyc;
            if (i >= 3 && i < 41 && !HOLD) hold_drop = 1;
            apply(1'($urandom), 0, 0, 0);
            if (i >= 3 && i < 41 && !HOLD) hold_drop = 1;
        end
        check("alt_latency", 64'(t_done - t_match), 64'd76);
        check("alt_cfg", CFG, ONES);
        check("alt_hold", hold_drop, 0);

        // Abort after 20 payload bits, then abort on the parity edge
        saw_done = 0;
        send_frame(37'h0A5A5A5A5A, 1, 0, 24);
        check("abort20_state", {BUSY, HOLD, ERR}, 3'b000);
        check("abort20_cfg", CFG, ONES);
        send_frame(37'h0123456789, 1, 0, 41);
        check("abortpar_state", {BUSY, DONE}, 2'b00);
        check("abortpar_cfg", CFG, ONES);
        check("abort_no_done", saw_done, 0);

        // Reset mid-frame after a commit restores the default word
        p1 = {$urandom, $urandom};
        p2 = {$urandom, $urandom};
        send_frame(p1, 1, 0, -1);
        check("pre_rst_cfg", CFG, p1);
        for (int i = 0; i < 34; i++) apply(frame_bit(p2, 1, i), 1, 0, 0);
        apply(0, 1, 0, 1);
        check("rst_cfg", CFG, CFG_DEF);
        check("rst_flags", {BUSY, HOLD, DONE, ERR}, 4'b0000);
        saw_done = 0;
        send_frame(p2, 1, 0, -1);
        check("resend_cfg", CFG, p2);
        check("resend_done", saw_done, 1);

        // Randomized frames with gaps, junk, occasional abort/reset, bad parity
        for (int n = 0; n < 40; n++) begin
            int junk;
            junk = $urandom_range(5);
            for (int j = 0; j < junk; j++) begin
                b = 1'($urandom);
                apply(b, 1'($urandom), $urandom_range(9) == 0, $urandom_range(49) == 0);
            end
            pr = {$urandom, $urandom};
            send_frame(pr, $urandom_range(3) != 0, $urandom_range(40),
                       ($urandom_range(5) == 0) ? int'($urandom_range(41)) : -1);
        end
        apply(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clb_cfg_loader.md
# clb_cfg_loader

Serial configuration loader for one `clb28`-style logic block. It receives a bit-serial configuration frame and searches for a preamble. It shifts the configuration bits into a shadow register and checks even parity. On success it commits the shadow register atomically to the parallel configuration word that drives the block's LUT contents, mux selects, combinational mode, DQ muxes and flop/latch select. A failed or aborted frame never alters the live configuration.

## Interface

- `CFGW`, 37: configuration word width.
- `PREW`, 4: preamble length in bits.
- `PRE`, 4'b1011: preamble pattern, first-received bit is MSB.

Ports (clock and reset first):

- `K`  in  1  clock. Everything is on the rising edge.
- `RST`  in  1  reset. Synchronous, active-high.
- `DIN`  in  1  serial configuration data.
- `DVALID`  in  1  `DIN` is sampled on edges where this is 1. Other edges are ignored.
- `ABORT`  in  1  discards the frame in progress and returns to IDLE.
- `CFG`  out  `CFGW`  live configuration word (registered).
- `HOLD`  out  1  high in LOAD and PARITY. Tells the CLB to hold its storage element.
- `BUSY`  out  1  high in any state other than IDLE.
- `DONE`  out  1  one-cycle pulse on a successful commit.
- `ERR`  out  1  sticky parity-failure flag.

## Operation

CFG field map, MSB to LSB:

- [36:35] mux2select
- [34:33] mux3select
- [32:31] mux4select
- [30:29] mux5select
- [28:27] mux6select
- [26:11] mem
- [10:9] comboption
- [8:6] o2m1_0, o2m2_0, o2m3_0
- [5:3] o2m1_1, o2m2_1, o2m3_1
- [2:1] DQmux1, DQmux2
- [0] floporlatch

CFG reset value, by field: 10, 10, 10, 00, 00, 16'b0000000100010110, 00, 000, 111, 00, 0.

States:

- **IDLE**
  - Each valid bit shifts into a `PREW`-bit sync register.
  - When the register equals `PRE`, go to LOAD, clear `ERR`, clear the bit counter and clear the parity accumulator.
  - A match is recognised on the edge that samples the last preamble bit.
- **LOAD**
  - Each valid bit shifts into the shadow register MSB-first and XORs into the parity accumulator. The counter increments.
  - After bit `CFGW` is sampled, go to PARITY.
  - Preamble patterns inside the payload are ignored.
- **PARITY**
  - The next valid bit is the parity bit.
  - If accumulator XOR bit is 0: `CFG` takes the shadow value, `DONE` pulses, go to IDLE.
  - Otherwise: `CFG` is unchanged, `ERR` is set, go to IDLE.
- The sync register is cleared whenever IDLE is entered. A new preamble therefore needs `PREW` fresh bits.
- `ABORT` in LOAD or PARITY: return to IDLE and discard the shadow. `CFG` and `ERR` are unchanged and `DONE` does not pulse.
- `ABORT` in IDLE has no effect.
- `ABORT` and the parity bit on the same edge: abort wins, no commit.
- Bit counter is 6 bits wide and saturates logic at `CFGW`. It must not wrap.

## Timing

- Reset values:
  - `CFG` = default above.
  - `HOLD`, `BUSY`, `DONE`, `ERR` = 0.
  - State = IDLE.
  - Shadow, counter, accumulator and sync register = 0.
- `RST` during LOAD or PARITY restores every reset value on that edge, including `CFG`.
- Commit latency: `CFG` and `DONE` change on the edge that samples the parity bit. `DONE` is high for exactly one cycle.
- Frame length is `PREW` + `CFGW` + 1 = 42 valid bits. With `DVALID` held high, `DONE` is seen 38 edges after the last preamble edge.
- `DVALID` gaps stall all progress. State, counter and `HOLD` are held indefinitely; there is no timeout.
- `HOLD` and `BUSY` rise on the preamble-match edge and fall on the commit/fail/abort edge.
- Back-to-back frames are allowed. The next preamble may begin on the edge after `DONE`.

## Test plan

- Reset with no stimulus: `CFG` equals the default field values, all flags 0. A 20-bit `DIN` stream of 1s gives no `BUSY` (no preamble match).
- Good frame, `DVALID`=1: send 1011, then 37 bits all set to 1, then parity 1 → `DONE` pulses once, `CFG`=37'h1FFFFFFFFF, `ERR`=0.
- Same frame with parity 0 → `ERR`=1, `CFG` still the default. A following good frame clears `ERR` at its preamble and commits.
- Good frame with `DVALID` low on every other cycle → same `CFG` as the `DVALID`=1 case, `DONE` at twice the latency, `HOLD` high throughout.
- `ABORT` after 20 payload bits, and separately on the parity edge → IDLE, `CFG` unchanged, `DONE` never asserted.
- `RST` after 30 payload bits following a prior commit → `CFG` returns to the default, `BUSY`=0. A re-sent frame then commits normally.
